// File: rtl/common.sv
// Shared decode-stage types, opcodes and the immediate generator.
package common;

    localparam int unsigned REGISTER_FILE_SIZE = 32;
    // Widest datapath the ID/EX record can carry; narrower XLEN values are zero-padded.
    localparam int unsigned XLEN_MAX = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef logic [31:0] instruction_type;

    typedef enum logic [1:0] {AluAdd, AluBranch, AluRtype, AluItype} alu_op_type;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        alu_op_type alu_op;
    } control_type;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } branch_predict_type;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] rs1_data;
        logic [XLEN_MAX-1:0] rs2_data;
        logic [XLEN_MAX-1:0] imm;
        control_type         ctrl;
        branch_predict_type  branch;
        logic                compressed;
    } id_ex_type;

    function automatic logic [31:0] immediate_extension(input instruction_type instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'h000};
            OP_JAL: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode-level control decode for the ID/EX record.
module control_unit
    import common::*;
(
    input  logic [6:0]  opcode,
    output control_type control
);

    always_comb begin
        control = '0;
        case (opcode)
            OP_REG:    begin control.reg_write = 1'b1; control.alu_op = AluRtype; end
            OP_IMM:    begin
                control.reg_write = 1'b1;
                control.alu_src   = 1'b1;
                control.alu_op    = AluItype;
            end
            OP_LOAD:   begin
                control.reg_write  = 1'b1;
                control.mem_read   = 1'b1;
                control.mem_to_reg = 1'b1;
                control.alu_src    = 1'b1;
            end
            OP_STORE:  begin control.mem_write = 1'b1; control.alu_src = 1'b1; end
            OP_BRANCH: begin control.branch = 1'b1; control.alu_op = AluBranch; end
            OP_JAL:    begin control.reg_write = 1'b1; control.jump = 1'b1; end
            OP_JALR:   begin
                control.reg_write = 1'b1;
                control.jump      = 1'b1;
                control.alu_src   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin control.reg_write = 1'b1; control.alu_src = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with x0 hard-wired to zero and writeback-to-read bypass.
module register_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          write_en,
    input  logic [REG_AW-1:0]             write_id,
    input  logic [XLEN-1:0]               write_data,
    input  logic [REG_AW-1:0]             read_id1,
    input  logic [REG_AW-1:0]             read_id2,
    output logic [XLEN-1:0]               read_data1,
    output logic [XLEN-1:0]               read_data2,
    output logic [NUM_REGS-1:0][XLEN-1:0] debug_reg
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic                          wr_live;

    assign wr_live = write_en && (write_id != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else if (wr_live) begin
            regs_q[write_id] <= write_data;
        end
    end

    always_comb begin
        read_data1 = regs_q[read_id1];
        read_data2 = regs_q[read_id2];
        if (read_id1 == '0)                       read_data1 = '0;
        else if (wr_live && write_id == read_id1) read_data1 = write_data;
        if (read_id2 == '0)                       read_data2 = '0;
        else if (wr_live && write_id == read_id2) read_data2 = write_data;
    end

    assign debug_reg = regs_q;

endmodule

// File: rtl/rvc_expander.sv
// Expands a 16-bit RVC instruction into its RV32I form; unsupported encodings become a NOP.
module rvc_expander
    import common::*;
(
    input  instruction_type instr_in,
    output instruction_type instr_out,
    output logic            compressed
);

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] lw_off;
    logic [20:0] j_off;
    logic [12:0] b_off;

    always_comb begin
        c      = instr_in[15:0];
        rd     = c[11:7];
        rs2    = c[6:2];
        rdp    = {2'b01, c[4:2]};
        rs1p   = {2'b01, c[9:7]};
        lw_off = {5'b0, c[5], c[12:10], c[6], 2'b00};
        j_off  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        b_off  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        compressed = (instr_in[1:0] != 2'b11);
        instr_out  = instr_in;
        if (compressed) begin
            instr_out = NOP_INSTR;
            case ({c[1:0], c[15:13]})
                5'b00_010: instr_out = {lw_off, rs1p, 3'b010, rdp, OP_LOAD};
                5'b00_110: instr_out = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], OP_STORE};
                5'b01_000: instr_out = {{6{c[12]}}, c[12], rs2, rd, 3'b000, rd, OP_IMM};
                5'b01_010: instr_out = {{6{c[12]}}, c[12], rs2, 5'd0, 3'b000, rd, OP_IMM};
                5'b01_011: begin
                    // rd==2 is c.addi16sp, which is not expanded here
                    if (rd != 5'd0 && rd != 5'd2 && {c[12], rs2} != 6'd0)
                        instr_out = {{14{c[12]}}, c[12], rs2, rd, OP_LUI};
                end
                5'b01_101: instr_out = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd0, OP_JAL};
                5'b01_110, 5'b01_111:
                    instr_out = {b_off[12], b_off[10:5], 5'd0, rs1p, 2'b00, c[13], b_off[4:1],
                                 b_off[11], OP_BRANCH};
                5'b10_000: begin
                    if (!c[12] && rd != 5'd0) instr_out = {7'b0, rs2, rd, 3'b001, rd, OP_IMM};
                end
                5'b10_100: begin
                    if (rs2 != 5'd0)
                        instr_out = {7'b0, rs2, c[12] ? rd : 5'd0, 3'b000, rd, OP_REG};
                    else if (rd != 5'd0)
                        instr_out = {12'b0, rd, 3'b000, c[12] ? 5'd1 : 5'd0, OP_JALR};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with registered ID/EX handshake, load-use stall, flush and writeback bypass.
// Define DECODE_RVC_EN to expand 16-bit compressed instructions before decode.
module decode_stage_pipe
    import common::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  instruction_type               instruction,
    input  logic [XLEN-1:0]               pc,
    input  branch_predict_type            branch_in,
    input  logic                          flush,
    input  logic                          ex_mem_read,
    input  logic [REG_AW-1:0]             ex_rd_id,
    input  logic                          write_en,
    input  logic [REG_AW-1:0]             write_id,
    input  logic [XLEN-1:0]               write_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [REG_AW-1:0]             reg_rd_id,
    output logic [XLEN-1:0]               pc_out,
    output logic [XLEN-1:0]               read_data1,
    output logic [XLEN-1:0]               read_data2,
    output logic [XLEN-1:0]               immediate_data,
    output control_type                   control_signals,
    output branch_predict_type            branch_out,
    output logic                          is_compressed,
    output logic [NUM_REGS-1:0][XLEN-1:0] debug_reg
);

    instruction_type   dec_instr;
    logic              dec_compressed;
    logic [REG_AW-1:0] rs1_id, rs2_id;
    logic [XLEN-1:0]   rf_data1, rf_data2;
    control_type       ctrl;
    logic              hazard, accept, advance;
    id_ex_type         id_ex_d, id_ex_q;

`ifdef DECODE_RVC_EN
    rvc_expander u_rvc (
        .instr_in   (instruction),
        .instr_out  (dec_instr),
        .compressed (dec_compressed)
    );
`else
    assign dec_instr      = instruction;
    assign dec_compressed = 1'b0;
`endif

    assign rs1_id = REG_AW'(dec_instr[19:15]);
    assign rs2_id = REG_AW'(dec_instr[24:20]);

    register_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_rf (
        .clk        (clk),
        .reset_n    (reset_n),
        .write_en   (write_en),
        .write_id   (write_id),
        .write_data (write_data),
        .read_id1   (rs1_id),
        .read_id2   (rs2_id),
        .read_data1 (rf_data1),
        .read_data2 (rf_data2),
        .debug_reg  (debug_reg)
    );

    control_unit u_ctrl (
        .opcode  (dec_instr[6:0]),
        .control (ctrl)
    );

    // Register fields are compared regardless of format; an occasional false stall is harmless.
    assign hazard   = ex_mem_read && (ex_rd_id != '0) && (ex_rd_id == rs1_id || ex_rd_id == rs2_id);
    assign advance  = !id_ex_q.valid || out_ready;
    assign in_ready = advance && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        id_ex_d            = '0;
        id_ex_d.valid      = 1'b1;
        id_ex_d.rd         = 5'(dec_instr[11:7]);
        id_ex_d.pc         = XLEN_MAX'(pc);
        id_ex_d.rs1_data   = XLEN_MAX'(rf_data1);
        id_ex_d.rs2_data   = XLEN_MAX'(rf_data2);
        id_ex_d.imm        = XLEN_MAX'($signed(immediate_extension(dec_instr)));
        id_ex_d.ctrl       = ctrl;
        id_ex_d.branch     = branch_in;
        id_ex_d.compressed = dec_compressed;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q <= '0;
        end else if (flush) begin
            id_ex_q.valid <= 1'b0;
        end else if (accept) begin
            id_ex_q <= id_ex_d;
        end else if (advance) begin
            id_ex_q.valid <= 1'b0;
        end
    end

    assign out_valid       = id_ex_q.valid;
    assign reg_rd_id       = REG_AW'(id_ex_q.rd);
    assign pc_out          = XLEN'(id_ex_q.pc);
    assign read_data1      = XLEN'(id_ex_q.rs1_data);
    assign read_data2      = XLEN'(id_ex_q.rs2_data);
    assign immediate_data  = XLEN'(id_ex_q.imm);
    assign control_signals = id_ex_q.ctrl;
    assign branch_out      = id_ex_q.branch;
    assign is_compressed   = id_ex_q.compressed;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised scoreboard bench for decode_stage_pipe plus directed corner cases.
module tb_decode_stage_pipe;
    import common::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid, in_ready, flush, ex_mem_read, write_en, out_valid, out_ready;
    instruction_type    instruction;
    logic [31:0]        pc, write_data, pc_out, read_data1, read_data2, immediate_data;
    branch_predict_type branch_in, branch_out;
    logic [4:0]         ex_rd_id, write_id, reg_rd_id;
    control_type        control_signals;
    logic               is_compressed;
    logic [31:0][31:0]  debug_reg;

    decode_stage_pipe #(.XLEN(32), .NUM_REGS(32), .REG_AW(5)) dut (
        .clk (clk), .reset_n (reset_n), .in_valid (in_valid), .in_ready (in_ready),
        .instruction (instruction), .pc (pc), .branch_in (branch_in), .flush (flush),
        .ex_mem_read (ex_mem_read), .ex_rd_id (ex_rd_id), .write_en (write_en),
        .write_id (write_id), .write_data (write_data), .out_valid (out_valid),
        .out_ready (out_ready), .reg_rd_id (reg_rd_id), .pc_out (pc_out),
        .read_data1 (read_data1), .read_data2 (read_data2), .immediate_data (immediate_data),
        .control_signals (control_signals), .branch_out (branch_out),
        .is_compressed (is_compressed), .debug_reg (debug_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] pc, d1, d2, imm;
        logic [8:0]  ctrl;
        logic [32:0] br;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e, e;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_regs [32];
    bit          m_valid;
    logic [6:0]  ops [10];
    logic [4:0]  rs1, rs2;
    bit          hz, exp_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? 32'(v - (1 << w)) : 32'(v);
    endfunction

    // Immediate value by instruction format, rebuilt from the ISA's field layout.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return sx(int'(i[31:20]), 12);
            7'b0100011: return sx(int'({i[31:25], i[11:7]}), 12);
            7'b1100011: return sx(int'({i[31], i[7], i[30:25], i[11:8]}), 12) << 1;
            7'b0110111, 7'b0010111: return {i[31:12], 12'h000};
            7'b1101111: return sx(int'({i[31], i[19:12], i[20], i[30:21]}), 20) << 1;
            default: return 32'h0;
        endcase
    endfunction

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op[1:0]}
    function automatic logic [8:0] ref_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 9'b1000_000_10;
            7'b0010011: return 9'b1000_100_11;
            7'b0000011: return 9'b1101_100_00;
            7'b0100011: return 9'b0010_100_00;
            7'b1100011: return 9'b0000_010_01;
            7'b1101111: return 9'b1000_001_00;
            7'b1100111: return 9'b1000_101_00;
            7'b0110111, 7'b0010111: return 9'b1000_100_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] a,
                                          input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd", 64'(reg_rd_id), 64'(mon_e.rd));
                chk("pc_out", 64'(pc_out), 64'(mon_e.pc));
                chk("rd1", 64'(read_data1), 64'(mon_e.d1));
                chk("rd2", 64'(read_data2), 64'(mon_e.d2));
                chk("imm", 64'(immediate_data), 64'(mon_e.imm));
                chk("ctrl", 64'(control_signals), 64'(mon_e.ctrl));
                chk("branch", 64'(branch_out), 64'(mon_e.br));
                chk("is_compressed", 64'(is_compressed), 64'(0));
            end
        end
    end

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_valid = 1'b0;
        reset_n = 1'b0; in_valid = 1'b0; instruction = '0; pc = '0; branch_in = '0;
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd_id = '0; write_en = 1'b0;
        write_id = '0; write_data = '0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_pc_out", 64'(pc_out), 64'(0));
        chk("reset_rd1", 64'(read_data1), 64'(0));
        chk("reset_ctrl", 64'(control_signals), 64'(0));
        chk("reset_x5", 64'(debug_reg[5]), 64'(0));
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid    = ($urandom_range(0, 9) < 8);
            instruction = $urandom;
            instruction[6:0]   = ops[$urandom_range(0, 9)];
            instruction[11:7]  = 5'($urandom_range(0, 7));
            instruction[19:15] = 5'($urandom_range(0, 7));
            instruction[24:20] = 5'($urandom_range(0, 7));
            pc          = $urandom;
            branch_in   = {1'($urandom_range(0, 1)), 32'($urandom)};
            flush       = ($urandom_range(0, 9) == 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rd_id    = 5'($urandom_range(0, 7));
            write_en    = 1'($urandom_range(0, 1));
            write_id    = 5'($urandom_range(0, 7));
            write_data  = $urandom;
            out_ready   = ($urandom_range(0, 9) < 7);
            #1;
            rs1 = instruction[19:15];
            rs2 = instruction[24:20];
            hz  = ex_mem_read && ex_rd_id != 0 && (ex_rd_id == rs1 || ex_rd_id == rs2);
            exp_rdy = (!m_valid || out_ready) && !hz && !flush;
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (flush && m_valid && sb_q.size() != 0) void'(sb_q.pop_front());
            if (in_valid && exp_rdy) begin
                e.rd   = instruction[11:7];
                e.pc   = pc;
                e.d1   = (rs1 == 0) ? 32'h0 : (write_en && write_id == rs1) ? write_data : m_regs[rs1];
                e.d2   = (rs2 == 0) ? 32'h0 : (write_en && write_id == rs2) ? write_data : m_regs[rs2];
                e.imm  = ref_imm(instruction);
                e.ctrl = ref_ctrl(instruction[6:0]);
                e.br   = branch_in;
                sb_q.push_back(e);
            end
            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_rdy) m_valid = 1'b1;
            else if (!m_valid || out_ready) m_valid = 1'b0;
            if (write_en && write_id != 0) m_regs[write_id] = write_data;
            step();
            chk("out_valid", 64'(out_valid), 64'(m_valid));
        end

        in_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; write_en = 1'b0; out_ready = 1'b1;
        step(); step();
        mon_en = 1'b0;
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        for (int r = 0; r < 32; r++) chk($sformatf("regfile_x%0d", r), 64'(debug_reg[r]), 64'(m_regs[r]));
        sb_q.delete();

        // Bypass: writeback of x5 in the same cycle it is read.
        write_en = 1'b1; write_id = 5'd5; write_data = 32'hDEAD_BEEF;
        instruction = add_i(5'd1, 5'd5, 5'd0); in_valid = 1'b1;
        #1 chk("bypass_in_ready", 64'(in_ready), 64'(1));
        step();
        chk("bypass_valid", 64'(out_valid), 64'(1));
        chk("bypass_rd1", 64'(read_data1), 64'(32'hDEAD_BEEF));

        // Load-use stall, then issue with unchanged PC.
        write_en = 1'b0; instruction = add_i(5'd4, 5'd3, 5'd2); pc = 32'h100;
        ex_mem_read = 1'b1; ex_rd_id = 5'd3;
        #1 chk("loaduse_in_ready", 64'(in_ready), 64'(0));
        step();
        chk("loaduse_bubble", 64'(out_valid), 64'(0));
        ex_mem_read = 1'b0;
        #1 chk("loaduse_release", 64'(in_ready), 64'(1));
        step();
        chk("loaduse_issue", 64'(out_valid), 64'(1));
        chk("loaduse_pc", 64'(pc_out), 64'(32'h100));
        chk("loaduse_rd", 64'(reg_rd_id), 64'(4));

        // Backpressure holds the ID/EX record.
        out_ready = 1'b0; pc = 32'h200; instruction = add_i(5'd6, 5'd1, 5'd1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", 64'(in_ready), 64'(0));
            step();
            chk("bp_pc_hold", 64'(pc_out), 64'(32'h100));
            chk("bp_valid_hold", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        #1 chk("bp_release", 64'(in_ready), 64'(1));
        step();
        chk("bp_next_pc", 64'(pc_out), 64'(32'h200));

        // Flush beats a pending instruction.
        flush = 1'b1; pc = 32'h300;
        #1 chk("flush_in_ready", 64'(in_ready), 64'(0));
        step();
        chk("flush_valid", 64'(out_valid), 64'(0));
        flush = 1'b0;

        // x0 is never written and never causes a stall.
        in_valid = 1'b0; write_en = 1'b1; write_id = 5'd0; write_data = 32'd5;
        step();
        chk("x0_write", 64'(debug_reg[0]), 64'(0));
        write_en = 1'b0; ex_mem_read = 1'b1; ex_rd_id = 5'd0;
        instruction = add_i(5'd4, 5'd0, 5'd0); in_valid = 1'b1;
        #1 chk("x0_no_stall", 64'(in_ready), 64'(1));
        step();
        ex_mem_read = 1'b0;

`ifdef DECODE_RVC_EN
        instruction = 32'h0000_4505;
        step();
        chk("rvc_ctrl", 64'(control_signals), 64'(ref_ctrl(7'b0010011)));
        chk("rvc_imm", 64'(immediate_data), 64'(1));
        chk("rvc_rd", 64'(reg_rd_id), 64'(10));
        chk("rvc_flag", 64'(is_compressed), 64'(1));
`endif

        // Reset while the ID/EX register holds an instruction.
        write_en = 1'b1; write_id = 5'd5; write_data = 32'd7;
        instruction = add_i(5'd1, 5'd5, 5'd0); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; write_en = 1'b0; out_ready = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        chk("pre_reset_x5", 64'(debug_reg[5]), 64'(7));
        reset_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'(0));
        chk("mid_reset_rd1", 64'(read_data1), 64'(0));
        for (int r = 0; r < 32; r++) chk($sformatf("mid_reset_x%0d", r), 64'(debug_reg[r]), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
